rvfi_imem_responder: RTL
========================

Name: rvfi_imem_responder

Overview:
- Instruction-memory responder for riscv-formal harnesses: serves core fetch requests over a valid/ready request/response pair.
- Returned instruction data is consistent with the constant (imem_addr, imem_data) pair that the imem consistency check asserts against.
- The halfword at imem_addr always reads as imem_data; every other halfword comes from the free fill_data input (solver- or bench-driven).
- Parameterised fixed latency with in-order buffering of outstanding fetches.

Parameters:
- XLEN, 32, address width (matches RISCV_FORMAL_XLEN).
- LATENCY, 1, cycles from request accept to response valid; legal range 1..15.
- DEPTH, 4, maximum outstanding fetches (FIFO entries); legal range 1..16, power of two.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_addr  in  XLEN  constant checked halfword address (driven from the check's rand reg).
- imem_data  in  16  constant halfword stored at imem_addr.
- fill_data  in  32  arbitrary data for non-matching halfwords, sampled at accept.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  XLEN  fetch address; bit 0 ignored (treated as 0).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_addr  out  XLEN  address of returned fetch (bit 0 = 0).
- rsp_data  out  32  fetched word: [15:0] at rsp_addr, [31:16] at rsp_addr+2.
- outstanding  out  $clog2(DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- Reset (reset_n low, async): FIFO empty, pointers 0, outstanding 0, rsp_valid 0, req_ready 1, rsp_addr/rsp_data 0. Any in-flight fetch is discarded; no response is emitted after reset.
- Accept: req_valid && req_ready on the rising edge. req_ready = (outstanding < DEPTH). There is no same-cycle bypass of a pop, so a full FIFO deasserts req_ready even when rsp_ready is high.
- Data formation at accept, using a = {req_addr[XLEN-1:1],1'b0}:
  - lo = (a == imem_addr) ? imem_data : fill_data[15:0]
  - hi = ((a+2) mod 2^XLEN == imem_addr) ? imem_data : fill_data[31:16]
  - Addition wraps; a = 0xFFFFFFFE compares its hi half against 0x00000000.
  - imem_addr bit 0 set: it never matches, so all data comes from fill_data.
- Each entry stores addr, data and a 4-bit countdown initialised to LATENCY-1.
- All countdowns that are nonzero decrement every cycle, including while the head is stalled.
- Head presentation: rsp_valid = FIFO non-empty && head countdown == 0.
  - Accept at edge N gives rsp_valid high in cycle N+LATENCY at the earliest.
  - Ordering is strictly in-order; later entries wait behind the head even if their countdown is 0.
- Response hold: while rsp_valid && !rsp_ready, rsp_addr/rsp_data/rsp_valid stay stable.
- Pop: rsp_valid && rsp_ready at the edge. The next head is presented the following cycle if its countdown is 0, giving back-to-back responses.
- Simultaneous accept and pop in the same cycle: outstanding is unchanged and both pointers advance.
- Pointer wrap: modulo DEPTH.
- Throughput: with DEPTH >= LATENCY+1, one fetch per cycle is sustained.
- outstanding:
  - increments on accept-only, decrements on pop-only.
  - never exceeds DEPTH and never underflows; a bench assertion covers both.
- fill_data is sampled only at accept; later changes do not affect stored entries.

Test Plan:
- Single fetch, LATENCY=1: imem_addr=0x100, imem_data=0xBEEF, fill=0x12345678, req_addr=0x100 accepted at edge 0 -> rsp_valid in cycle 1, rsp_data=0x1234BEEF, rsp_addr=0x100.
- High-half match: req_addr=0xFE, same imem pair -> rsp_data=0xBEEF5678. Also req_addr=0xFF -> bit 0 ignored, rsp_addr=0xFE, same data.
- Address wrap: imem_addr=0x0, req_addr=0xFFFFFFFE, fill=0xAAAA5555 -> rsp_data=0xBEEF5555.
- Backpressure and full, DEPTH=4, LATENCY=3: hold rsp_ready=0 and issue 5 requests -> 4 accepted, req_ready=0, outstanding=4, head stable. Release rsp_ready -> 4 responses on consecutive cycles in request order, then req_ready=1.
- Streaming, LATENCY=2, DEPTH=4: req_valid and rsp_ready held high for 20 cycles -> 20 accepts in total, responses one per cycle starting 2 cycles after the first accept, outstanding steady at 2.
- Reset mid-operation: 3 entries outstanding, reset_n pulsed low asynchronously between edges -> rsp_valid drops immediately, outstanding=0. No stale responses appear after reset_n rises; the next request returns correct data.

Source files
------------

// File: rtl/rvfi_imem_responder.sv
`default_nettype none
// rvfi_imem_responder: fixed-latency, in-order instruction fetch responder for riscv-formal.
// The halfword at imem_addr always reads as imem_data; every other halfword comes from fill_data.
module rvfi_imem_responder #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [XLEN-1:0]            imem_addr,
  input  logic [15:0]                imem_data,
  input  logic [31:0]                fill_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [XLEN-1:0]            req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [XLEN-1:0]            rsp_addr,
  output logic [31:0]                rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 CNT_W    = $clog2(DEPTH + 1);
  localparam logic [3:0]         CD_INIT  = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);

  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       cd_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             empty;
  logic             head_ready;
  logic             accept;
  logic             pop;
  logic [XLEN-1:0]  acc_addr;
  logic [XLEN-1:0]  acc_addr_hi;
  logic [15:0]      acc_lo;
  logic [15:0]      acc_hi;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty      = (count == '0);
  assign req_ready  = (count < CNT_MAX);
  assign head_ready = !empty && (cd_q[rd_ptr] == 4'd0);
  assign accept     = req_valid && req_ready;
  assign pop        = head_ready && rsp_ready;

  // Fetches are halfword aligned; the upper half address wraps modulo 2^XLEN.
  assign acc_addr    = {req_addr[XLEN-1:1], 1'b0};
  assign acc_addr_hi = acc_addr + XLEN'(2);
  assign acc_lo      = (acc_addr == imem_addr) ? imem_data : fill_data[15:0];
  assign acc_hi      = (acc_addr_hi == imem_addr) ? imem_data : fill_data[31:16];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        cd_q[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Countdowns run on every entry, so a stalled head does not delay those behind it.
      for (int i = 0; i < DEPTH; i++) begin
        if (accept && (wr_ptr == PTR_W'(i))) begin
          addr_q[i] <= acc_addr;
          data_q[i] <= {acc_hi, acc_lo};
          cd_q[i]   <= CD_INIT;
        end else if (cd_q[i] != 4'd0) begin
          cd_q[i] <= cd_q[i] - 4'd1;
        end
      end
      if (accept) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (accept && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !accept) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign rsp_valid   = head_ready;
  assign rsp_addr    = head_ready ? addr_q[rd_ptr] : '0;
  assign rsp_data    = head_ready ? data_q[rd_ptr] : '0;
  assign outstanding = count;

endmodule
`default_nettype wire
